// File: rtl/flash_audio_streamer.sv
// Streams 32-bit flash words over Avalon-MM reads and plays them out one sample per tick.
// Build macro FLASH_STREAM_LOOP_EN makes the clip wrap at its ends instead of stopping in DONE.
module flash_audio_streamer #(
   parameter int unsigned           ADDR_WIDTH   = 23,
   parameter int unsigned           SAMPLE_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
   parameter logic [ADDR_WIDTH-1:0] END_ADDR     = ADDR_WIDTH'('h7FFFF)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    restart,
   input  logic                    reverse,
   input  logic                    sample_tick,
   input  logic                    flash_mem_waitrequest,
   input  logic                    flash_mem_readdatavalid,
   input  logic [31:0]             flash_mem_readdata,
   output logic                    flash_mem_read,
   output logic [ADDR_WIDTH-1:0]   flash_mem_address,
   output logic [SAMPLE_WIDTH-1:0] audio_out,
   output logic                    valid_read_flag,
   output logic                    underrun,
   output logic                    done
);

   localparam int unsigned     NumLanes = 32 / SAMPLE_WIDTH;
   localparam int unsigned     LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);

   typedef enum logic [2:0] {StIdle, StReq, StWaitData, StFull, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LaneW-1:0]        lane_q, lane_d;
   logic [31:0]             buf_q, buf_d;
   logic                    valid_q, valid_d;
   logic                    dir_q, dir_d;
   logic                    discard_q, discard_d;
   logic [SAMPLE_WIDTH-1:0] audio_q, audio_d;
   logic                    underrun_q, underrun_d;
   logic                    done_q, done_d;

   logic [SAMPLE_WIDTH-1:0] lane_sample;
   logic                    last_lane;
   logic                    at_bound;
   logic [ADDR_WIDTH-1:0]   ptr_step;

   assign lane_sample = SAMPLE_WIDTH'(buf_q >> (32'(lane_q) * SAMPLE_WIDTH));
   assign last_lane   = dir_q ? (lane_q == '0) : (lane_q == LastLane);

   // dir_q is the direction latched when the current word was captured.
   always_comb begin
      if (dir_q) begin
         at_bound = (ptr_q == START_ADDR);
         ptr_step = at_bound ? END_ADDR : ptr_q - 1'b1;
      end else begin
         at_bound = (ptr_q == END_ADDR);
         ptr_step = at_bound ? START_ADDR : ptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      buf_d      = buf_q;
      valid_d    = valid_q;
      dir_d      = dir_q;
      discard_d  = discard_q;
      audio_d    = audio_q;
      underrun_d = 1'b0;
      done_d     = done_q;
      if (restart) begin
         ptr_d   = reverse ? END_ADDR : START_ADDR;
         lane_d  = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
         unique case (state_q)
            // A request already on the bus must finish; its data beat is dropped later.
            StReq: begin
               discard_d = 1'b1;
               if (!flash_mem_waitrequest) state_d = StWaitData;
            end
            StWaitData: begin
               discard_d = !flash_mem_readdatavalid;
               if (flash_mem_readdatavalid) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end else begin
         underrun_d = sample_tick && enable && !valid_q && (state_q != StDone);
         unique case (state_q)
            StIdle: begin
               if (enable) begin
                  state_d = StReq;
                  addr_d  = ptr_q;
               end
            end
            StReq: begin
               if (!flash_mem_waitrequest) state_d = StWaitData;
            end
            StWaitData: begin
               if (flash_mem_readdatavalid) begin
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = StIdle;
                  end else begin
                     buf_d   = flash_mem_readdata;
                     valid_d = 1'b1;
                     dir_d   = reverse;
                     lane_d  = reverse ? LastLane : '0;
                     state_d = StFull;
                  end
               end
            end
            StFull: begin
               if (sample_tick && enable) begin
                  audio_d = lane_sample;
                  if (last_lane) begin
                     valid_d = 1'b0;
`ifdef FLASH_STREAM_LOOP_EN
                     ptr_d   = ptr_step;
                     addr_d  = ptr_step;
                     state_d = StReq;
`else
                     if (at_bound) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                     end else begin
                        ptr_d   = ptr_step;
                        addr_d  = ptr_step;
                        state_d = StReq;
                     end
`endif
                  end else begin
                     lane_d = dir_q ? lane_q - 1'b1 : lane_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= START_ADDR;
         addr_q     <= START_ADDR;
         lane_q     <= '0;
         buf_q      <= '0;
         valid_q    <= 1'b0;
         dir_q      <= 1'b0;
         discard_q  <= 1'b0;
         audio_q    <= '0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         buf_q      <= buf_d;
         valid_q    <= valid_d;
         dir_q      <= dir_d;
         discard_q  <= discard_d;
         audio_q    <= audio_d;
         underrun_q <= underrun_d;
         done_q     <= done_d;
      end
   end

   assign flash_mem_read    = (state_q == StReq);
   assign flash_mem_address = addr_q;
   assign audio_out         = audio_q;
   assign valid_read_flag   = valid_q;
   assign underrun          = underrun_q;
   assign done              = done_q;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Scoreboard bench: two streamer instances (8-bit and 16-bit samples) against a flash model.
`timescale 1ns/1ps
module tb_flash_audio_streamer;

   typedef struct packed {
      logic        is_sample;
      logic        und;
      logic [15:0] val;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n = 1'b0;

   int errors = 0;
   int checks = 0;

   // Instance A: 8-bit samples, clip 0x100..0x101
   logic        enable_a, restart_a, reverse_a, tick_a, wait_a, rdv_a;
   logic [31:0] rdata_a;
   logic        read_a, valid_a, und_a, done_a;
   logic [22:0] addr_a;
   logic [7:0]  audio_a;
   // Instance B: 16-bit samples, clip 0x20..0x21
   logic        enable_b, restart_b, reverse_b, tick_b, wait_b, rdv_b;
   logic [31:0] rdata_b;
   logic        read_b, valid_b, und_b, done_b;
   logic [22:0] addr_b;
   logic [15:0] audio_b;

   flash_audio_streamer #(
      .ADDR_WIDTH(23), .SAMPLE_WIDTH(8), .START_ADDR(23'h100), .END_ADDR(23'h101)
   ) u_dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable_a), .restart(restart_a),
      .reverse(reverse_a), .sample_tick(tick_a), .flash_mem_waitrequest(wait_a),
      .flash_mem_readdatavalid(rdv_a), .flash_mem_readdata(rdata_a),
      .flash_mem_read(read_a), .flash_mem_address(addr_a), .audio_out(audio_a),
      .valid_read_flag(valid_a), .underrun(und_a), .done(done_a)
   );

   flash_audio_streamer #(
      .ADDR_WIDTH(23), .SAMPLE_WIDTH(16), .START_ADDR(23'h20), .END_ADDR(23'h21)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable_b), .restart(restart_b),
      .reverse(reverse_b), .sample_tick(tick_b), .flash_mem_waitrequest(wait_b),
      .flash_mem_readdatavalid(rdv_b), .flash_mem_readdata(rdata_b),
      .flash_mem_read(read_b), .flash_mem_address(addr_b), .audio_out(audio_b),
      .valid_read_flag(valid_b), .underrun(und_b), .done(done_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t smp(input logic [15:0] v);
      exp_t e;
      e.is_sample = 1'b1; e.und = 1'b0; e.val = v;
      return e;
   endfunction

   function automatic exp_t hold(input logic u);
      exp_t e;
      e.is_sample = 1'b0; e.und = u; e.val = '0;
      return e;
   endfunction

   function automatic logic [31:0] mem_a(input logic [22:0] a);
      case (a)
         23'h100: return 32'hDDCCBBAA;
         23'h101: return 32'h12345678;
         default: return 32'hEEEEEEEE;
      endcase
   endfunction

   function automatic logic [31:0] mem_b(input logic [22:0] a);
      case (a)
         23'h20:  return 32'h22221111;
         23'h21:  return 32'h44443333;
         default: return 32'hEEEEEEEE;
      endcase
   endfunction

   exp_t        sb_a[$];
   exp_t        sb_b[$];
   logic [22:0] exp_addr_a[$];
   logic [22:0] exp_addr_b[$];
   int          lat_a = 2, cnt_a = 0, acc_a = 0;
   int          cnt_b = 0;
   logic [22:0] raddr_a, raddr_b;

   // Flash models: a read seen with waitrequest low at a falling edge is accepted on the next rise.
   always @(negedge clk) begin
      rdv_a = 1'b0;
      if (!reset_n) cnt_a = 0;
      else begin
         if (cnt_a != 0) begin
            cnt_a--;
            if (cnt_a == 0) begin rdv_a = 1'b1; rdata_a = mem_a(raddr_a); end
         end
         if (read_a && !wait_a) begin
            cnt_a = lat_a; raddr_a = addr_a; acc_a++;
            if (exp_addr_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_read_addr: got read of %0h expected no read", addr_a);
            end else check("a_read_addr", addr_a, exp_addr_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      rdv_b = 1'b0;
      if (!reset_n) cnt_b = 0;
      else begin
         if (cnt_b != 0) begin
            cnt_b--;
            if (cnt_b == 0) begin rdv_b = 1'b1; rdata_b = mem_b(raddr_b); end
         end
         if (read_b && !wait_b) begin
            cnt_b = 2; raddr_b = addr_b;
            if (exp_addr_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_read_addr: got read of %0h expected no read", addr_b);
            end else check("b_read_addr", addr_b, exp_addr_b.pop_front());
         end
      end
   end

   // Sample monitors: after each tick pop one expectation; otherwise audio holds, underrun low.
   logic tick_seen_a = 1'b0, tick_seen_b = 1'b0;
   always @(posedge clk) begin
      tick_seen_a <= tick_a;
      tick_seen_b <= tick_b;
   end

   logic [15:0] exp_audio_a = '0, exp_audio_b = '0;
   always @(negedge clk) begin
      exp_t e;
      logic eu;
      eu = 1'b0;
      if (!reset_n) exp_audio_a = '0;
      else if (tick_seen_a) begin
         if (sb_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_scoreboard: got tick expected empty queue entry");
         end else begin
            e = sb_a.pop_front();
            if (e.is_sample) exp_audio_a = e.val;
            eu = e.und;
         end
      end
      check("a_audio", audio_a, exp_audio_a[7:0]);
      check("a_underrun", und_a, eu);
   end

   always @(negedge clk) begin
      exp_t e;
      logic eu;
      eu = 1'b0;
      if (!reset_n) exp_audio_b = '0;
      else if (tick_seen_b) begin
         if (sb_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_scoreboard: got tick expected empty queue entry");
         end else begin
            e = sb_b.pop_front();
            if (e.is_sample) exp_audio_b = e.val;
            eu = e.und;
         end
      end
      check("b_audio", audio_b, exp_audio_b);
      check("b_underrun", und_b, eu);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_a_exp(input exp_t e);
      sb_a.push_back(e);
      tick_a = 1'b1;
      step();
      tick_a = 1'b0;
   endtask

   task automatic tick_b_exp(input exp_t e);
      sb_b.push_back(e);
      tick_b = 1'b1;
      step();
      tick_b = 1'b0;
   endtask

   task automatic wait_valid_a(input string name);
      int n = 0;
      while (valid_a !== 1'b1 && n < 60) begin step(); n++; end
      check(name, valid_a, 1);
   endtask

   task automatic wait_valid_b(input string name);
      int n = 0;
      while (valid_b !== 1'b1 && n < 60) begin step(); n++; end
      check(name, valid_b, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_before;
      int n;
      enable_a = 0; restart_a = 0; reverse_a = 0; tick_a = 0; wait_a = 0;
      enable_b = 0; restart_b = 0; reverse_b = 0; tick_b = 0; wait_b = 0;
      repeat (3) step();
      check("a_rst_read", read_a, 0);
      check("a_rst_valid", valid_a, 0);
      check("a_rst_done", done_a, 0);
      check("b_rst_read", read_b, 0);
      check("b_rst_valid", valid_b, 0);
      check("b_rst_done", done_b, 0);
      reset_n = 1'b1;
      step();

      // Forward playback of two words, then the clip end
      exp_addr_a.push_back(23'h100);
      enable_a = 1;
      wait_valid_a("a_fwd_word0_valid");
      enable_a = 0;
      tick_a_exp(hold(1'b0));
      enable_a = 1;
      exp_addr_a.push_back(23'h101);
      tick_a_exp(smp(16'hAA)); tick_a_exp(smp(16'hBB));
      tick_a_exp(smp(16'hCC)); tick_a_exp(smp(16'hDD));
      wait_valid_a("a_fwd_word1_valid");
`ifdef FLASH_STREAM_LOOP_EN
      exp_addr_a.push_back(23'h100);
`endif
      tick_a_exp(smp(16'h78)); tick_a_exp(smp(16'h56));
      tick_a_exp(smp(16'h34)); tick_a_exp(smp(16'h12));
`ifdef FLASH_STREAM_LOOP_EN
      check("a_fwd_done", done_a, 0);
      tick_a_exp(hold(1'b1));
      wait_valid_a("a_fwd_wrap_valid");
`else
      check("a_fwd_done", done_a, 1);
      tick_a_exp(hold(1'b0));
      repeat (4) step();
      check("a_done_no_read", read_a, 0);
`endif

      // Reverse playback from the clip end
      reverse_a = 1; restart_a = 1;
      exp_addr_a.push_back(23'h101);
      step();
      restart_a = 0;
      check("a_restart_clears_done", done_a, 0);
      wait_valid_a("a_rev_word1_valid");
      exp_addr_a.push_back(23'h100);
      tick_a_exp(smp(16'h12)); tick_a_exp(smp(16'h34));
      tick_a_exp(smp(16'h56)); tick_a_exp(smp(16'h78));
      wait_valid_a("a_rev_word0_valid");
`ifdef FLASH_STREAM_LOOP_EN
      exp_addr_a.push_back(23'h101);
`endif
      tick_a_exp(smp(16'hDD)); tick_a_exp(smp(16'hCC));
      tick_a_exp(smp(16'hBB)); tick_a_exp(smp(16'hAA));
`ifdef FLASH_STREAM_LOOP_EN
      check("a_rev_done", done_a, 0);
      wait_valid_a("a_rev_wrap_valid");
`else
      check("a_rev_done", done_a, 1);
`endif

      // Waitrequest stall: request held stable, then a tick while starved
      reverse_a = 0; wait_a = 1; restart_a = 1;
      step();
      restart_a = 0;
      n = 0;
      while (read_a !== 1'b1 && n < 20) begin step(); n++; end
      check("a_stall_req_seen", read_a, 1);
      for (int i = 0; i < 5; i++) begin
         check("a_stall_read", read_a, 1);
         check("a_stall_addr", addr_a, 23'h100);
         step();
      end
      acc_before = acc_a;
      exp_addr_a.push_back(23'h100);
      lat_a = 4;
      wait_a = 0;
      tick_a_exp(hold(1'b1));
      wait_valid_a("a_stall_valid");
      check("a_stall_one_accept", acc_a, acc_before + 1);
      exp_addr_a.push_back(23'h101);
      tick_a_exp(smp(16'hAA)); tick_a_exp(smp(16'hBB));
      tick_a_exp(smp(16'hCC)); tick_a_exp(smp(16'hDD));

      // Restart while waiting for data: the stale beat must be dropped
      lat_a = 6;
      n = 0;
      while (read_a !== 1'b0 && n < 20) begin step(); n++; end
      check("a_discard_in_wait", read_a, 0);
      exp_addr_a.push_back(23'h100);
      restart_a = 1;
      step();
      restart_a = 0;
      for (int i = 0; i < 8; i++) begin
         check("a_discard_valid_low", valid_a, 0);
         step();
      end
      wait_valid_a("a_discard_new_valid");
      tick_a_exp(smp(16'hAA));

      // Restart and tick together: restart wins, lane returns to the start
      exp_addr_a.push_back(23'h100);
      restart_a = 1;
      tick_a_exp(hold(1'b0));
      restart_a = 0;
      check("a_restart_empties", valid_a, 0);
      wait_valid_a("a_restart_tick_valid");
      tick_a_exp(smp(16'hAA));
      enable_a = 0;

      // 16-bit samples, two-word clip
      exp_addr_b.push_back(23'h20);
      enable_b = 1;
      wait_valid_b("b_word0_valid");
      exp_addr_b.push_back(23'h21);
      tick_b_exp(smp(16'h1111)); tick_b_exp(smp(16'h2222));
      wait_valid_b("b_word1_valid");
`ifdef FLASH_STREAM_LOOP_EN
      exp_addr_b.push_back(23'h20);
`endif
      tick_b_exp(smp(16'h3333)); tick_b_exp(smp(16'h4444));
`ifdef FLASH_STREAM_LOOP_EN
      check("b_done", done_b, 0);
      tick_b_exp(hold(1'b1));
      wait_valid_b("b_wrap_valid");
`else
      check("b_done", done_b, 1);
      tick_b_exp(hold(1'b0));
      repeat (4) step();
      check("b_done_no_read", read_b, 0);
      check("b_done_held", done_b, 1);
`endif
      enable_b = 0;

      repeat (4) step();
      check("a_sb_drained", sb_a.size(), 0);
      check("b_sb_drained", sb_b.size(), 0);
      check("a_addr_drained", exp_addr_a.size(), 0);
      check("b_addr_drained", exp_addr_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
